// File: rtl/p65c816_useq_if.sv
// Bus bundle between the 65C816 microcode sequencer and its environment.
// The master drives step controls and conditions; the slave is the sequencer.
interface p65c816_useq_if;
    logic        CE;
    logic        RDY;
    logic [7:0]  D_IN;
    logic [2:0]  STATE_CTRL;
    logic        M_FLAG;
    logic        X_FLAG;
    logic        DL_ZERO;
    logic        BR_TAKEN;
    logic        IRQ_REQ;
    logic        NMI_EDGE;
    logic [7:0]  IR;
    logic [2:0]  MC;
    logic [10:0] ROM_ADDR;
    logic        SYNC;
    logic [1:0]  VEC_SEL;
    logic        NMI_ACK;
    logic        WAITING;
    logic        STOPPED;

    modport master (
        output CE, RDY, D_IN, STATE_CTRL,
        output M_FLAG, X_FLAG, DL_ZERO, BR_TAKEN,
        output IRQ_REQ, NMI_EDGE,
        input  IR, MC, ROM_ADDR, SYNC, VEC_SEL,
        input  NMI_ACK, WAITING, STOPPED
    );

    modport slave (
        input  CE, RDY, D_IN, STATE_CTRL,
        input  M_FLAG, X_FLAG, DL_ZERO, BR_TAKEN,
        input  IRQ_REQ, NMI_EDGE,
        output IR, MC, ROM_ADDR, SYNC, VEC_SEL,
        output NMI_ACK, WAITING, STOPPED
    );
endinterface

// File: rtl/p65c816_useq.sv
// 65C816 microcode sequencer: steps {IR, MC} through the microcode ROM,
// handles conditional skips, branches, WAI/STP and NMI/IRQ vectoring.
module p65c816_useq (
    input logic            CLK,
    input logic            RST,
    p65c816_useq_if.slave  bus
);
    typedef enum logic [2:0] {
        SC_NEXT   = 3'b000,
        SC_END    = 3'b001,
        SC_MSKIP  = 3'b010,
        SC_XSKIP  = 3'b011,
        SC_DSKIP  = 3'b100,
        SC_BRANCH = 3'b101,
        SC_WAI    = 3'b110,
        SC_STP    = 3'b111
    } sc_e;

    logic [7:0] ir_q, ir_d;
    logic [2:0] mc_q, mc_d;
    logic [1:0] vec_sel_q, vec_sel_d;
    logic       nmi_ack_q, nmi_ack_d;
    logic       waiting_q, waiting_d;
    logic       stopped_q, stopped_d;
    logic       nmi_pend_q, nmi_pend_d;

    sc_e  sc;
    logic step_en;
    logic end_op;

    assign sc     = sc_e'(bus.STATE_CTRL);
    assign end_op = (sc == SC_END) ||
                    ((sc == SC_BRANCH) && !bus.BR_TAKEN);

    always_comb begin
        step_en    = bus.CE && bus.RDY && !stopped_q;
        ir_d       = ir_q;
        mc_d       = mc_q;
        vec_sel_d  = vec_sel_q;
        nmi_ack_d  = 1'b0;
        waiting_d  = waiting_q;
        stopped_d  = stopped_q;
        nmi_pend_d = nmi_pend_q;

        if (step_en) begin
            if (end_op) begin
                mc_d = 3'd0;
                if (nmi_pend_q) begin
                    ir_d       = 8'h00;
                    vec_sel_d  = 2'b10;
                    nmi_ack_d  = 1'b1;
                    nmi_pend_d = 1'b0;
                end else if (bus.IRQ_REQ) begin
                    ir_d      = 8'h00;
                    vec_sel_d = 2'b11;
                end else begin
                    ir_d      = bus.D_IN;
                    vec_sel_d = 2'b00;
                end
            end else begin
                case (sc)
                    SC_MSKIP: mc_d = mc_q + (bus.M_FLAG  ? 3'd2 : 3'd1);
                    SC_XSKIP: mc_d = mc_q + (bus.X_FLAG  ? 3'd2 : 3'd1);
                    SC_DSKIP: mc_d = mc_q + (bus.DL_ZERO ? 3'd2 : 3'd1);
                    SC_WAI: begin
                        // Wake does not consume the NMI; the next END vectors it.
                        if (nmi_pend_q || bus.IRQ_REQ) begin
                            mc_d      = mc_q + 3'd1;
                            waiting_d = 1'b0;
                        end else begin
                            waiting_d = 1'b1;
                        end
                    end
                    SC_STP:  stopped_d = 1'b1;
                    default: mc_d = mc_q + 3'd1;
                endcase
            end
        end

        // A new edge beats a same-cycle clear.
        if (bus.NMI_EDGE) nmi_pend_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ir_q       <= 8'h00;
            mc_q       <= 3'd0;
            vec_sel_q  <= 2'b01;
            nmi_ack_q  <= 1'b0;
            waiting_q  <= 1'b0;
            stopped_q  <= 1'b0;
            nmi_pend_q <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            mc_q       <= mc_d;
            vec_sel_q  <= vec_sel_d;
            nmi_ack_q  <= nmi_ack_d;
            waiting_q  <= waiting_d;
            stopped_q  <= stopped_d;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    assign bus.IR       = ir_q;
    assign bus.MC       = mc_q;
    assign bus.ROM_ADDR = {ir_q, mc_q};
    assign bus.SYNC     = !stopped_q && end_op;
    assign bus.VEC_SEL  = vec_sel_q;
    assign bus.NMI_ACK  = nmi_ack_q;
    assign bus.WAITING  = waiting_q;
    assign bus.STOPPED  = stopped_q;
endmodule

// File: tb/tb_p65c816_useq.sv
// Scoreboard bench for p65c816_useq: directed scenarios then random steps,
// predicted by a cycle-level behavioural model of the sequencer rules.
module tb_p65c816_useq;
    logic CLK;
    logic RST;

    p65c816_useq_if u_if ();

    p65c816_useq dut (
        .CLK (CLK),
        .RST (RST),
        .bus (u_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] ir;
        logic [2:0] mc;
        logic [1:0] vec;
        logic       ack;
        logic       wt;
        logic       st;
        logic       sync;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic sync_seen;

    // Model state
    int m_ir = 0, m_mc = 0, m_vec = 1;
    bit m_ack = 0, m_wt = 0, m_st = 0, m_pend = 0;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drv(input bit r, input bit ce, input bit rdy,
                       input int sc, input int d, input bit m,
                       input bit x, input bit z, input bit b,
                       input bit irq, input bit nmi);
        exp_t e;
        bit   is_end;
        int   adv;
        @(negedge CLK);
        RST              = r;
        u_if.CE          = ce;
        u_if.RDY         = rdy;
        u_if.STATE_CTRL  = 3'(sc);
        u_if.D_IN        = 8'(d);
        u_if.M_FLAG      = m;
        u_if.X_FLAG      = x;
        u_if.DL_ZERO     = z;
        u_if.BR_TAKEN    = b;
        u_if.IRQ_REQ     = irq;
        u_if.NMI_EDGE    = nmi;

        is_end = (sc == 1) || (sc == 5 && !b);
        e.sync = !m_st && is_end;

        if (r) begin
            m_ir = 0; m_mc = 0; m_vec = 1;
            m_ack = 0; m_wt = 0; m_st = 0; m_pend = 0;
        end else begin
            bit pend_next;
            pend_next = m_pend;
            m_ack = 0;
            if (!m_st && ce && rdy) begin
                if (is_end) begin
                    m_mc = 0;
                    if (m_pend) begin
                        m_ir = 0; m_vec = 2; m_ack = 1; pend_next = 0;
                    end else if (irq) begin
                        m_ir = 0; m_vec = 3;
                    end else begin
                        m_ir = d; m_vec = 0;
                    end
                end else if (sc == 6) begin
                    if (m_pend || irq) begin
                        m_mc = (m_mc + 1) % 8; m_wt = 0;
                    end else begin
                        m_wt = 1;
                    end
                end else if (sc == 7) begin
                    m_st = 1;
                end else begin
                    adv = 1;
                    if ((sc == 2 && m) || (sc == 3 && x) || (sc == 4 && z))
                        adv = 2;
                    m_mc = (m_mc + adv) % 8;
                end
            end
            if (nmi) pend_next = 1;
            m_pend = pend_next;
        end

        e.ir  = 8'(m_ir);
        e.mc  = 3'(m_mc);
        e.vec = 2'(m_vec);
        e.ack = m_ack;
        e.wt  = m_wt;
        e.st  = m_st;
        sb_q.push_back(e);
    endtask

    task automatic step(input int sc, input int d, input bit b,
                        input bit irq);
        drv(0, 1, 1, sc, d, 0, 0, 0, b, irq, 0);
    endtask

    // SYNC is combinational; capture it late in the cycle.
    initial forever begin
        @(negedge CLK);
        #3;
        sync_seen = u_if.SYNC;
    end

    initial forever begin
        exp_t e;
        @(posedge CLK);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sync",     16'(sync_seen),     16'(e.sync));
            chk("ir",       16'(u_if.IR),       16'(e.ir));
            chk("mc",       16'(u_if.MC),       16'(e.mc));
            chk("rom_addr", 16'(u_if.ROM_ADDR), 16'({e.ir, e.mc}));
            chk("vec_sel",  16'(u_if.VEC_SEL),  16'(e.vec));
            chk("nmi_ack",  16'(u_if.NMI_ACK),  16'(e.ack));
            chk("waiting",  16'(u_if.WAITING),  16'(e.wt));
            chk("stopped",  16'(u_if.STOPPED),  16'(e.st));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        u_if.CE = 0; u_if.RDY = 0; u_if.D_IN = 0; u_if.STATE_CTRL = 0;
        u_if.M_FLAG = 0; u_if.X_FLAG = 0; u_if.DL_ZERO = 0;
        u_if.BR_TAKEN = 0; u_if.IRQ_REQ = 0; u_if.NMI_EDGE = 0;

        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0);
        drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 8'hA9, 0, 0);
        drv(0, 1, 1, 2, 0, 1, 0, 0, 0, 0, 0);
        step(1, 8'hA9, 0, 0);
        drv(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0);

        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) drv(0, 1, 0, 1, 8'h11, 0, 0, 0, 0, 1, 0);
        step(1, 8'h22, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 8'h33, 0, 1);
        drv(0, 1, 1, 1, 8'h44, 0, 0, 0, 0, 1, 1);

        step(1, 8'hCB, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        repeat (10) step(6, 0, 0, 0);
        step(6, 0, 0, 1);

        drv(0, 1, 1, 3, 0, 0, 1, 0, 0, 0, 0);
        drv(0, 1, 1, 4, 0, 0, 0, 1, 0, 0, 0);
        step(7, 0, 0, 0);
        repeat (20) step(0, 0, 0, 0);
        drv(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        step(5, 8'hEA, 0, 0);
        step(5, 8'h55, 1, 0);

        repeat (1500) begin
            int sc;
            sc = ($urandom_range(0, 31) == 0) ? 7 : $urandom_range(0, 6);
            drv($urandom_range(0, 63) == 0,
                $urandom_range(0, 7) != 0,
                $urandom_range(0, 7) != 0,
                sc, $urandom_range(0, 255),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 15) == 0);
        end

        @(posedge CLK);
        #3;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
